// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   fwd_sel_t  : EX operand forwarding mux select
//   state_t    : multiply-occupancy FSM state
//   addr_match : register address compare where x0 never matches
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Addresses are zero-extended to 32 bits by the caller, so any AW up to 32 works.
  function automatic logic addr_match(input logic [31:0] a, input logic [31:0] b);
    return (a != 32'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand.
//   src_addr_i           : source register of the EX instruction
//   mem_addr_i/we/rd     : MEM-stage destination, write enable, load flag
//   wb_addr_i/we         : WB-stage destination, write enable
//   fwd_o                : FWD_MEM, FWD_WB or FWD_REG (MEM has priority)
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] src_addr_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic          mem_we_i,
  input  logic          mem_rd_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic          wb_we_i,
  output fwd_sel_t      fwd_o
);

  always_comb begin
    fwd_o = FWD_REG;
    // A load in MEM has no data yet; its value is picked up from WB a cycle later.
    if (mem_we_i && !mem_rd_i && addr_match(32'(mem_addr_i), 32'(src_addr_i))) begin
      fwd_o = FWD_MEM;
    end else if (wb_we_i && addr_match(32'(wb_addr_i), 32'(src_addr_i))) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core: EX/ID operand forwarding,
// load-use stall, multi-cycle multiply occupancy of EX, branch flush, and
// saturating stall/flush performance counters.
//   Clock, nReset                    : clock, asynchronous active-low reset
//   RsAddrD/RtAddrD                  : ID source registers
//   RsAddrE/RtAddrE/RAddrE           : EX sources and destination
//   MemReadE, MulStartE              : EX instruction is a load / multiply
//   RAddrM/RegWriteM/MemReadM        : MEM destination, write enable, load flag
//   RAddrW/RegWriteW                 : WB destination, write enable
//   BranchTaken                      : branch resolved taken in EX
//   ClrCount                         : synchronous clear of both counters
//   ForwardA/B, ForwardSrcA/B        : EX and ID forwarding selects
//   StallF, StallD, FlushD, BubbleE  : pipeline register controls
//   HoldE, MulBusy                   : multiply hold, FSM busy flag
//   StallCycles, FlushCount          : saturating performance counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned AW          = 5,
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned CW          = 16
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [AW-1:0] RsAddrD,
  input  logic [AW-1:0] RtAddrD,
  input  logic [AW-1:0] RsAddrE,
  input  logic [AW-1:0] RtAddrE,
  input  logic [AW-1:0] RAddrE,
  input  logic          MemReadE,
  input  logic          MulStartE,
  input  logic [AW-1:0] RAddrM,
  input  logic          RegWriteM,
  input  logic          MemReadM,
  input  logic [AW-1:0] RAddrW,
  input  logic          RegWriteW,
  input  logic          BranchTaken,
  input  logic          ClrCount,
  output logic [1:0]    ForwardA,
  output logic [1:0]    ForwardB,
  output logic          ForwardSrcA,
  output logic          ForwardSrcB,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          BubbleE,
  output logic          HoldE,
  output logic          MulBusy,
  output logic [CW-1:0] StallCycles,
  output logic [CW-1:0] FlushCount
);

  localparam bit          MultiCycle = (MULT_CYCLES > 1);
  localparam int unsigned CntW       = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES) : 1;
  localparam int unsigned CntInitInt = MultiCycle ? (MULT_CYCLES - 2) : 0;
  localparam logic [CntW-1:0] CntInit = CntW'(CntInitInt);

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  fwd_sel_t fwd_a, fwd_b;

  hazard_fwd_sel #(.AW(AW)) u_fwd_a (
    .src_addr_i (RsAddrE),
    .mem_addr_i (RAddrM),
    .mem_we_i   (RegWriteM),
    .mem_rd_i   (MemReadM),
    .wb_addr_i  (RAddrW),
    .wb_we_i    (RegWriteW),
    .fwd_o      (fwd_a)
  );

  hazard_fwd_sel #(.AW(AW)) u_fwd_b (
    .src_addr_i (RtAddrE),
    .mem_addr_i (RAddrM),
    .mem_we_i   (RegWriteM),
    .mem_rd_i   (MemReadM),
    .wb_addr_i  (RAddrW),
    .wb_we_i    (RegWriteW),
    .fwd_o      (fwd_b)
  );

  assign ForwardA    = fwd_a;
  assign ForwardB    = fwd_b;
  // ID-stage operands read the register file in the same cycle WB writes it.
  assign ForwardSrcA = RegWriteW && addr_match(32'(RAddrW), 32'(RsAddrD));
  assign ForwardSrcB = RegWriteW && addr_match(32'(RAddrW), 32'(RtAddrD));

  logic load_use;
  assign load_use = MemReadE && (addr_match(32'(RAddrE), 32'(RsAddrD)) ||
                                 addr_match(32'(RAddrE), 32'(RtAddrD)));

  // ---------------------------------------------------------------------------
  // Multiply occupancy FSM
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mul_hold;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (BranchTaken) begin
      // A taken branch squashes whatever is in EX, including a running multiply.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (MulStartE && MultiCycle) begin
            state_d = BUSY;
            cnt_d   = CntInit;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    mul_hold = 1'b0;
    unique case (state_q)
      IDLE:    mul_hold = MulStartE && MultiCycle;
      BUSY:    mul_hold = (cnt_q != '0);
      default: mul_hold = 1'b0;
    endcase
  end

  assign MulBusy = (state_q == BUSY);

  // ---------------------------------------------------------------------------
  // Pipeline control priority: branch > multiply hold > load-use
  // ---------------------------------------------------------------------------
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    FlushD  = 1'b0;
    BubbleE = 1'b0;
    HoldE   = 1'b0;
    if (BranchTaken) begin
      FlushD  = 1'b1;
      BubbleE = 1'b1;
    end else if (mul_hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      HoldE  = 1'b1;
    end else if (load_use) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      BubbleE = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ClrCount) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CW'(1);
      if (BranchTaken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule
